// File: rtl/dap_cmd_dispatcher_if.sv
// +--------------------------------------------------------------------+
// | dap_cmd_dispatcher_if : request, worker and response buses of the  |
// | DAP command dispatcher.                       Revision: 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

interface dap_cmd_dispatcher_if;
    logic        req_tvalid;
    logic        req_tready;
    logic [7:0]  req_tdata;
    logic [3:0]  worker_en;
    logic [3:0]  worker_start;
    logic [3:0]  worker_in_tvalid;
    logic [3:0]  worker_in_tready;
    logic [7:0]  worker_in_tdata;
    logic [3:0]  worker_out_tvalid;
    logic [31:0] worker_out_tdata;
    logic [3:0]  worker_done;
    logic        resp_tvalid;
    logic [7:0]  resp_tdata;
    logic        resp_done;

    // Dispatcher side
    modport master (
        input  req_tvalid, req_tdata, worker_in_tready,
               worker_out_tvalid, worker_out_tdata, worker_done,
        output req_tready, worker_en, worker_start, worker_in_tvalid,
               worker_in_tdata, resp_tvalid, resp_tdata, resp_done
    );

    // USB host and worker side
    modport slave (
        output req_tvalid, req_tdata, worker_in_tready,
               worker_out_tvalid, worker_out_tdata, worker_done,
        input  req_tready, worker_en, worker_start, worker_in_tvalid,
               worker_in_tdata, resp_tvalid, resp_tdata, resp_done
    );
endinterface

`default_nettype wire

// File: rtl/dap_cmd_dispatcher.sv
// +--------------------------------------------------------------------+
// | dap_cmd_dispatcher : routes a DAP command byte to one of four      |
// | workers and streams its response. Option: DAP_CMD_TIMEOUT_EN.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module dap_cmd_dispatcher #(
    parameter logic [7:0]  CMD0_ID        = 8'h09,
    parameter logic [7:0]  CMD1_ID        = 8'h00,
    parameter logic [7:0]  CMD2_ID        = 8'h02,
    parameter logic [7:0]  CMD3_ID        = 8'h05,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input wire                   hclk,
    input wire                   resetn,
    dap_cmd_dispatcher_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_RUN    = 3'd2,
        S_FINISH = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] worker_en_q, worker_en_d;
    logic       rsp_vld_q, rsp_vld_d;
    logic [7:0] rsp_dat_q, rsp_dat_d;
    logic       match;
    logic [1:0] match_sel;
    logic       timeout_hit;

    assign worker_en_d   = 4'hF;
    assign bus.worker_en = worker_en_q;

    // Lowest channel index wins when IDs are duplicated
    always_comb begin
        match     = 1'b1;
        match_sel = 2'd0;
        if (cmd_q == CMD0_ID)      match_sel = 2'd0;
        else if (cmd_q == CMD1_ID) match_sel = 2'd1;
        else if (cmd_q == CMD2_ID) match_sel = 2'd2;
        else if (cmd_q == CMD3_ID) match_sel = 2'd3;
        else                       match     = 1'b0;
    end

`ifdef DAP_CMD_TIMEOUT_EN
    logic [23:0] timeout_cnt_q, timeout_cnt_d;

    assign timeout_cnt_d = (state_q == S_RUN) ? timeout_cnt_q + 24'd1 : 24'd0;
    assign timeout_hit   = (state_q == S_RUN) && (timeout_cnt_q == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) timeout_cnt_q <= 24'd0;
        else         timeout_cnt_q <= timeout_cnt_d;
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d              = state_q;
        cmd_d                = cmd_q;
        sel_d                = sel_q;
        rsp_vld_d            = 1'b0;
        rsp_dat_d            = 8'h00;
        bus.req_tready       = 1'b0;
        bus.worker_start     = 4'h0;
        bus.worker_in_tvalid = 4'h0;
        bus.worker_in_tdata  = 8'h00;
        bus.resp_tvalid      = 1'b0;
        bus.resp_tdata       = 8'h00;
        bus.resp_done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Not ready until the first clock after reset release
                bus.req_tready = worker_en_q[0];
                if (worker_en_q[0] && bus.req_tvalid) begin
                    cmd_d   = bus.req_tdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.resp_tvalid = 1'b1;
                bus.resp_tdata  = cmd_q;
                if (match) begin
                    sel_d   = match_sel;
                    state_d = S_RUN;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_RUN: begin
                bus.worker_start[sel_q]     = 1'b1;
                bus.worker_in_tvalid[sel_q] = bus.req_tvalid;
                bus.worker_in_tdata         = bus.req_tdata;
                bus.req_tready              = bus.worker_in_tready[sel_q];
                rsp_vld_d                   = bus.worker_out_tvalid[sel_q];
                rsp_dat_d                   = bus.worker_out_tdata[{sel_q, 3'b000} +: 8];
                bus.resp_tvalid             = rsp_vld_q;
                bus.resp_tdata              = rsp_dat_q;
                if (bus.worker_done[sel_q]) state_d = S_FINISH;
                else if (timeout_hit)       state_d = S_ERR;
            end
            S_FINISH: begin
                // Only a byte captured alongside worker_done can still be pending here
                bus.resp_tvalid = rsp_vld_q;
                bus.resp_tdata  = rsp_dat_q;
                bus.resp_done   = 1'b1;
                state_d         = S_IDLE;
            end
            S_ERR: begin
                bus.resp_tvalid = 1'b1;
                bus.resp_tdata  = 8'hFF;
                bus.resp_done   = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'h00;
            sel_q       <= 2'd0;
            worker_en_q <= 4'h0;
            rsp_vld_q   <= 1'b0;
            rsp_dat_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            sel_q       <= sel_d;
            worker_en_q <= worker_en_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dap_cmd_dispatcher.sv
// +--------------------------------------------------------------------+
// | tb_dap_cmd_dispatcher : randomized self-checking bench for         |
// | dap_cmd_dispatcher.                          Revision: 1.0         |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_dap_cmd_dispatcher;

    localparam logic [7:0] IDS [4] = '{8'h09, 8'h00, 8'h02, 8'h05};
`ifdef DAP_CMD_TIMEOUT_EN
    localparam int C_DELAY = 2;
    localparam int C_MAXN  = 1;
`else
    localparam int C_DELAY = 300;
    localparam int C_MAXN  = 3;
`endif

    logic hclk   = 1'b0;
    logic resetn = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   last_done = -100;

    logic [7:0] mon_byte [$];
    int         mon_bcyc [$];
    int         mon_dcyc [$];

    dap_cmd_dispatcher_if bus ();

    dap_cmd_dispatcher #(
        .CMD0_ID        (IDS[0]),
        .CMD1_ID        (IDS[1]),
        .CMD2_ID        (IDS[2]),
        .CMD3_ID        (IDS[3]),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .hclk   (hclk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    always @(negedge hclk) begin
        cyc <= cyc + 1;
        if (resetn) begin
            if (bus.resp_tvalid) begin
                mon_byte.push_back(bus.resp_tdata);
                mon_bcyc.push_back(cyc);
            end
            if (bus.resp_done) mon_dcyc.push_back(cyc);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Reference routing: first listed ID equal to the command, else error
    function automatic int ref_channel(input logic [7:0] c);
        for (int i = 0; i < 4; i++) if (IDS[i] == c) return i;
        return -1;
    endfunction

    task automatic noise(input int ch);
        logic [3:0] keep;
        keep = ~(4'b0001 << ch);
        bus.worker_out_tvalid = 4'($urandom) & keep;
        bus.worker_done       = 4'($urandom) & keep;
        bus.worker_out_tdata  = $urandom;
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input int nreq, input int nresp,
                           input int stall0, input int delay);
        int         ch, b0, d0, stall;
        logic [7:0] b;
        logic [7:0] exp_b [$];
        logic [7:0] src   [$];
        logic [7:0] got   [$];
        ch = ref_channel(cmd);
        b0 = mon_byte.size();
        d0 = mon_dcyc.size();
        exp_b.push_back(cmd);
        bus.req_tdata  = cmd;
        bus.req_tvalid = 1'b1;
        #1;
        chk("idle_ready", bus.req_tready, 1);
        chk("idle_start", bus.worker_start, 0);
        tick();
        bus.req_tdata = 8'hA5;
        #1;
        chk("decode_ready", bus.req_tready, 0);
        chk("decode_start", bus.worker_start, 0);
        if (ch < 0) begin
            exp_b.push_back(8'hFF);
            tick();
            chk("err_ready", bus.req_tready, 0);
            chk("err_start", bus.worker_start, 0);
            bus.req_tvalid = 1'b0;
            tick();
        end else begin
            bus.req_tvalid = 1'b0;
            tick();
            repeat (delay) begin
                noise(ch);
                chk("run_start", bus.worker_start, 1 << ch);
                tick();
            end
            for (int i = 0; i < nreq; i++) begin
                b = 8'($urandom);
                src.push_back(b);
                bus.req_tdata  = b;
                bus.req_tvalid = 1'b1;
                stall = (i == 0) ? stall0 : int'($urandom_range(0, 2));
                for (int s = 0; s <= stall; s++) begin
                    bus.worker_in_tready     = 4'($urandom);
                    bus.worker_in_tready[ch] = (s == stall);
                    #1;
                    chk("run_start", bus.worker_start, 1 << ch);
                    chk("run_in_tvalid", bus.worker_in_tvalid, 1 << ch);
                    chk("run_in_tdata", bus.worker_in_tdata, b);
                    chk("run_req_tready", bus.req_tready, (s == stall));
                    if (bus.worker_in_tvalid[ch] && bus.worker_in_tready[ch])
                        got.push_back(bus.worker_in_tdata);
                    tick();
                end
            end
            bus.req_tvalid       = 1'b0;
            bus.worker_in_tready = 4'h0;
            chk("fwd_count", got.size(), src.size());
            foreach (got[i]) chk("fwd_byte", got[i], src[i]);
            for (int k = 0; k < nresp; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    noise(ch);
                    tick();
                end
                b = 8'($urandom);
                exp_b.push_back(b);
                noise(ch);
                bus.worker_out_tvalid[ch]          = 1'b1;
                bus.worker_out_tdata[ch*8 +: 8]    = b;
                tick();
            end
            noise(ch);
            tick();
            bus.worker_out_tvalid = 4'h0;
            bus.worker_done       = 4'h0;
            bus.worker_done[ch]   = 1'b1;
            #1;
            chk("done_start", bus.worker_start, 1 << ch);
            tick();
            bus.worker_done = 4'h0;
            #1;
            chk("finish_start", bus.worker_start, 0);
            chk("finish_ready", bus.req_tready, 0);
            tick();
        end
        chk("resp_count", mon_byte.size() - b0, exp_b.size());
        foreach (exp_b[i])
            if (b0 + i < mon_byte.size()) chk("resp_byte", mon_byte[b0+i], exp_b[i]);
        chk("done_count", mon_dcyc.size() - d0, 1);
        if (mon_dcyc.size() > d0 && mon_byte.size() >= b0 + exp_b.size()) begin
            chk("echo_after_prev_done", (mon_bcyc[b0] - last_done) >= 1, 1);
            if (ch < 0) begin
                chk("err_ff_next_cycle", mon_bcyc[b0+1] - mon_bcyc[b0], 1);
                chk("err_done_with_ff", mon_dcyc[d0], mon_bcyc[b0+1]);
            end else begin
                chk("done_after_last_byte", mon_dcyc[d0] > mon_bcyc[b0+exp_b.size()-1], 1);
            end
            last_done = mon_dcyc[d0];
        end
    endtask

    initial begin
        logic [7:0] c;
        int         b0, d0;
        bus.req_tvalid        = 1'b1;
        bus.req_tdata         = 8'h09;
        bus.worker_in_tready  = 4'h0;
        bus.worker_out_tvalid = 4'h0;
        bus.worker_out_tdata  = 32'h0;
        bus.worker_done       = 4'h0;
        #12;
        chk("rst_en", bus.worker_en, 0);
        chk("rst_start", bus.worker_start, 0);
        chk("rst_resp_tvalid", bus.resp_tvalid, 0);
        chk("rst_resp_tdata", bus.resp_tdata, 0);
        chk("rst_resp_done", bus.resp_done, 0);
        chk("rst_req_tready", bus.req_tready, 0);
        bus.req_tvalid = 1'b0;
        @(negedge hclk);
        resetn = 1'b1;
        tick();
        chk("en_after_reset", bus.worker_en, 4'hF);

        run_cmd(IDS[0], 2, 1, 0, C_DELAY);
        run_cmd(8'h7E, 0, 0, 0, 0);
        run_cmd(IDS[2], 2, 1, 5, 0);
        run_cmd(IDS[0], 0, 1, 0, 0);
        run_cmd(IDS[1], 1, 2 < C_MAXN ? 2 : C_MAXN, 0, 0);

        // Reset pulse in the middle of a channel-0 command
        bus.req_tdata  = IDS[0];
        bus.req_tvalid = 1'b1;
        tick();
        bus.req_tvalid = 1'b0;
        tick();
        chk("mid_run_start", bus.worker_start, 4'h1);
        bus.req_tvalid       = 1'b1;
        bus.worker_in_tready = 4'hF;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_start", bus.worker_start, 0);
        chk("async_en", bus.worker_en, 0);
        chk("async_in_tvalid", bus.worker_in_tvalid, 0);
        chk("async_req_tready", bus.req_tready, 0);
        chk("async_resp_tvalid", bus.resp_tvalid, 0);
        chk("async_resp_done", bus.resp_done, 0);
        bus.req_tvalid       = 1'b0;
        bus.worker_in_tready = 4'h0;
        @(negedge hclk);
        resetn = 1'b1;
        tick();
        chk("en_after_pulse", bus.worker_en, 4'hF);
        run_cmd(IDS[0], 1, 1, 0, 0);

        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 4))
                0:       c = IDS[0];
                1:       c = IDS[1];
                2:       c = IDS[2];
                3:       c = IDS[3];
                default: c = 8'($urandom);
            endcase
            run_cmd(c, int'($urandom_range(0, C_MAXN)), int'($urandom_range(0, C_MAXN)),
                    int'($urandom_range(0, 2)), 0);
        end

`ifdef DAP_CMD_TIMEOUT_EN
        b0 = mon_byte.size();
        d0 = mon_dcyc.size();
        bus.req_tdata  = IDS[1];
        bus.req_tvalid = 1'b1;
        tick();
        bus.req_tvalid = 1'b0;
        repeat (20) tick();
        chk("to_count", mon_byte.size() - b0, 2);
        chk("to_done_count", mon_dcyc.size() - d0, 1);
        if (mon_byte.size() >= b0 + 2 && mon_dcyc.size() > d0) begin
            chk("to_echo", mon_byte[b0], IDS[1]);
            chk("to_ff", mon_byte[b0+1], 8'hFF);
            chk("to_ff_delay", mon_bcyc[b0+1] - mon_bcyc[b0], 17);
            chk("to_done_with_ff", mon_dcyc[d0], mon_bcyc[b0+1]);
        end
`else
        b0 = 0;
        d0 = 0;
        chk("no_stray_bytes", mon_byte.size() >= b0 && mon_dcyc.size() >= d0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
